// File: rtl/diff_of_3bit_pair_stream.sv
// Two-stage valid/ready pipeline computing the signed difference a - b of two
// unsigned operands, plus a saturating running total of delivered differences.
module diff_of_3bit_pair_stream #(
  parameter int WIDTH     = 3,
  parameter int ACC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       diff,
  output logic                 neg,
  input  logic                 acc_clear,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_sat
);

  localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH:0]       diff_q, diff_d;
  logic                 neg_q, neg_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 acc_sat_q, acc_sat_d;

  logic                 s1_adv, s2_adv, out_xfer;
  logic                 sat_base;
  logic signed [ACC_WIDTH:0] acc_base, diff_ext, acc_sum;

  // Each stage may load whenever the stage after it is empty or draining.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && rst_n;
  assign out_xfer = s2_valid_q && out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    neg_d      = neg_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = a;
        b_d = b;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = {1'b0, a_q} - {1'b0, b_q};
        neg_d  = diff_d[WIDTH];
      end
    end
  end

  // Clear takes effect before the transferred difference is added.
  always_comb begin
    acc_base  = acc_clear ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
    sat_base  = acc_clear ? 1'b0 : acc_sat_q;
    diff_ext  = {{(ACC_WIDTH-WIDTH){diff_q[WIDTH]}}, diff_q};
    acc_sum   = acc_base + diff_ext;
    acc_d     = acc_base[ACC_WIDTH-1:0];
    acc_sat_d = sat_base;
    if (out_xfer) begin
      if (acc_sum > ACC_MAX) begin
        acc_d     = ACC_MAX[ACC_WIDTH-1:0];
        acc_sat_d = 1'b1;
      end else if (acc_sum < ACC_MIN) begin
        acc_d     = ACC_MIN[ACC_WIDTH-1:0];
        acc_sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      acc_sat_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign neg       = neg_q;
  assign acc       = acc_q;
  assign acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_diff_of_3bit_pair_stream.sv
// Self-checking bench: queue scoreboard with an integer accumulator model,
// a boundary vector table, and hand-written stall/clear/reset sequences.
module tb_diff_of_3bit_pair_stream;

  localparam int W  = 3;
  localparam int AW = 6;
  localparam int ACC_HI = (1 << (AW - 1)) - 1;
  localparam int ACC_LO = -(1 << (AW - 1));

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, neg, acc_clear, acc_sat;
  logic [W-1:0]  a, b;
  logic [W:0]    diff;
  logic [AW-1:0] acc;

  always #5 clk = ~clk;

  diff_of_3bit_pair_stream #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .neg(neg), .acc_clear(acc_clear), .acc(acc), .acc_sat(acc_sat)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp_bits;
    bit           exp_neg;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_acc = 0;
  bit m_sat = 1'b0;
  int cyc = 0;
  int n_out = 0;
  bit stall_prev = 1'b0;
  logic [W:0] diff_prev;
  bit last_in_x, last_out_x;
  bit log_first = 1'b0;
  int first_acc_cyc = -1;
  int first_out_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample between edges, then advance the reference model on the edge.
  task automatic cycle();
    bit in_x, out_x;
    int d;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    if (!rst_n) check("in_ready_in_reset", in_ready, 0);
    else begin
      check("acc", $signed(acc), m_acc);
      check("acc_sat", acc_sat, m_sat);
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_diff", diff, diff_prev);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          check("diff", $signed(diff), exp_q[0]);
          check("neg", neg, int'(exp_q[0] < 0));
        end
      end
    end
    if (log_first) begin
      if (in_x && first_acc_cyc < 0) first_acc_cyc = cyc;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
    end
    stall_prev = rst_n && out_valid && !out_ready;
    diff_prev  = diff;
    last_in_x  = in_x;
    last_out_x = out_x;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 0;
      m_sat = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (acc_clear) begin
        m_acc = 0;
        m_sat = 1'b0;
      end
      if (out_x && exp_q.size() > 0) begin
        d = exp_q.pop_front();
        n_out++;
        m_acc += d;
        if (m_acc > ACC_HI) begin m_acc = ACC_HI; m_sat = 1'b1; end
        if (m_acc < ACC_LO) begin m_acc = ACC_LO; m_sat = 1'b1; end
      end
      if (in_x) exp_q.push_back(int'(a) - int'(b));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic push(input int av, input int bv);
    bit got = 1'b0;
    in_valid = 1'b1;
    a = W'(av);
    b = W'(bv);
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      got = last_in_x;
    end
    check("push_accepted", got, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
  endtask

  vec_t vecs[6];

  initial begin
    bit holding;
    int pushed, budget;
    int seq_exp[3];

    vecs[0] = '{a: 3'd7, b: 3'd0, exp_bits: 4'b0111, exp_neg: 1'b0};
    vecs[1] = '{a: 3'd0, b: 3'd7, exp_bits: 4'b1001, exp_neg: 1'b1};
    vecs[2] = '{a: 3'd5, b: 3'd5, exp_bits: 4'b0000, exp_neg: 1'b0};
    vecs[3] = '{a: 3'd3, b: 3'd6, exp_bits: 4'b1101, exp_neg: 1'b1};
    vecs[4] = '{a: 3'd6, b: 3'd1, exp_bits: 4'b0101, exp_neg: 1'b0};
    vecs[5] = '{a: 3'd0, b: 3'd0, exp_bits: 4'b0000, exp_neg: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_clear = 1'b0; a = '0; b = '0;
    @(negedge clk);
    repeat (2) cycle();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_neg", neg, 0);
    check("rst_acc", acc, 0);
    check("rst_acc_sat", acc_sat, 0);
    check("rst_in_ready", in_ready, 1);

    // Exhaustive sweep, back to back.
    log_first = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      a = W'(i >> 3);
      b = W'(i & 7);
      cycle();
      check("sweep_accept", last_in_x, 1);
    end
    drain(4);
    log_first = 1'b0;
    check("sweep_latency", first_out_cyc - first_acc_cyc, 2);
    check("sweep_count", n_out, 64);

    // Boundary vectors, raw bit patterns.
    foreach (vecs[i]) begin
      bit seen = 1'b0;
      out_ready = 1'b1;
      push(int'(vecs[i].a), int'(vecs[i].b));
      for (int k = 0; k < 5 && !seen; k++) begin
        #1;
        if (out_valid) begin
          seen = 1'b1;
          check("vec_diff_bits", diff, vecs[i].exp_bits);
          check("vec_neg", neg, vecs[i].exp_neg);
        end
        cycle();
      end
      check("vec_delivered", seen, 1);
    end
    drain(3);

    // Stall with a full pipeline, then drain without bubbles.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 3'd5; b = 3'd2; cycle(); check("stall_acc1", last_in_x, 1);
    in_valid = 1'b1; a = 3'd1; b = 3'd6; cycle(); check("stall_acc2", last_in_x, 1);
    in_valid = 1'b1; a = 3'd3; b = 3'd3;
    #1;
    check("stall_in_ready_low", in_ready, 0);
    repeat (3) begin
      cycle();
      check("stall_no_accept", last_in_x, 0);
      check("stall_diff", $signed(diff), 3);
    end
    seq_exp = '{3, -5, 0};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain_valid", out_valid, 1);
      check("drain_diff", $signed(diff), seq_exp[k]);
      cycle();
      in_valid = 1'b0;
    end
    drain(2);

    // Random handshakes against the scoreboard.
    pushed = 0;
    budget = 0;
    holding = 1'b0;
    n_out = 0;
    while (pushed < 10000 && budget < 60000) begin
      if (!holding) begin
        in_valid = 1'($urandom % 2);
        a = W'($urandom);
        b = W'($urandom);
      end
      out_ready = 1'($urandom % 2);
      acc_clear = ($urandom % 20) == 0;
      cycle();
      if (last_in_x) pushed++;
      holding = in_valid && !last_in_x;
      budget++;
    end
    acc_clear = 1'b0;
    check("rand_budget", pushed, 10000);
    drain(4);
    check("rand_delivered", n_out, 10000);
    check("rand_leftover", exp_q.size(), 0);

    // Saturation: clear, +7 x5 then -7 x10.
    acc_clear = 1'b1; drain(1); acc_clear = 1'b0;
    for (int k = 0; k < 5; k++) push(7, 0);
    drain(3);
    check("sat_hi_acc", $signed(acc), 31);
    check("sat_hi_flag", acc_sat, 1);
    for (int k = 0; k < 10; k++) push(0, 7);
    drain(3);
    check("sat_lo_acc", $signed(acc), -32);
    check("sat_lo_flag", acc_sat, 1);

    // Clear coinciding with a transfer, then clear alone.
    acc_clear = 1'b1; drain(1); acc_clear = 1'b0;
    push(7, 0); push(7, 0); push(6, 0);
    drain(3);
    check("clr_pre_acc", $signed(acc), 20);
    out_ready = 1'b0;
    push(0, 4);
    cycle();
    #1;
    check("clr_hold_valid", out_valid, 1);
    check("clr_hold_diff", $signed(diff), -4);
    acc_clear = 1'b1; out_ready = 1'b1;
    cycle();
    acc_clear = 1'b0;
    #1;
    check("clr_xfer_acc", $signed(acc), -4);
    check("clr_xfer_sat", acc_sat, 0);
    acc_clear = 1'b1; drain(1); acc_clear = 1'b0;
    #1;
    check("clr_idle_acc", acc, 0);

    // Reset with two pairs in flight under a stall.
    push(2, 1);
    drain(3);
    check("rst_pre_acc", $signed(acc), 1);
    out_ready = 1'b0;
    push(4, 0); push(5, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_acc", acc, 0);
    check("rst2_acc_sat", acc_sat, 0);
    n_out = 0;
    drain(5);
    check("rst2_nothing_delivered", n_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
